pong_serve_seq: RTL and testbench
=================================

# pong_serve_seq

Game-flow sequencer for the Pong core: owns attract mode, the post-miss serve delay, the serve strobe and both score counters. It sits between the ball/paddle collision logic (miss/coin pulses in) and the ball motion and score display logic (enable, serve, score out). It replaces the discrete serve flip-flop chain and 555 serve timer with one synchronous FSM clocked in the system clock domain.

## Interface
- `SERVE_DELAY_FRAMES`, default 60: vblank ticks between a miss or coin and the serve; legal range 1–255.
- `WIN_SCORE`, default 11: score that ends the game; legal range 1–15.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `vblank_tick` in 1: one-cycle pulse per frame.
- `coin` in 1: one-cycle start pulse.
- `miss_left` in 1: one-cycle pulse; ball passed the left paddle.
- `miss_right` in 1: one-cycle pulse; ball passed the right paddle.
- `attract` out 1: high in attract mode.
- `ball_en` out 1: ball motion enable.
- `serve_n` out 1: active-low serve strobe; low for exactly one cycle.
- `serve_dir` out 1: 0 serves toward the left player, 1 toward the right.
- `score_l` out 4: left player score.
- `score_r` out 4: right player score.
- `game_over` out 1: one-cycle pulse when a score reaches `WIN_SCORE`.

## Operation
- States: ATTRACT, SERVE_WAIT, SERVE, PLAY. This is a Moore machine; all outputs are registered.
- Reset values:
  - state ATTRACT
  - `attract`=1, `ball_en`=1, `serve_n`=1, `serve_dir`=0
  - `score_l`=`score_r`=0, `game_over`=0
  - delay counter 0
- ATTRACT: `ball_en`=1.
  - `miss_*` are ignored.
  - `coin` clears both scores and the counter, sets `serve_dir`=0, and moves to SERVE_WAIT.
- SERVE_WAIT: `ball_en`=0, `attract`=0.
  - Each `vblank_tick` increments the 8-bit counter.
  - A tick arriving with counter == `SERVE_DELAY_FRAMES`-1 moves to SERVE and clears the counter.
- SERVE: `serve_n`=0 and `ball_en`=1 for one cycle, then unconditionally PLAY.
- PLAY: `ball_en`=1.
  - `miss_left`: `score_r`+1, `serve_dir`=0.
  - `miss_right`: `score_l`+1, `serve_dir`=1.
  - If the incremented score equals `WIN_SCORE`: pulse `game_over` and go to ATTRACT; scores hold their final values.
  - Otherwise clear the counter and go to SERVE_WAIT.
- Simultaneous `miss_left` and `miss_right`: `miss_left` wins and `miss_right` is dropped.
- `coin` together with `vblank_tick` in ATTRACT: coin is taken and the tick is not counted.
- Misses in SERVE_WAIT or SERVE are ignored.
- Scores never exceed `WIN_SCORE`; no wrap.

## Timing
- Input pulse at edge N: state and outputs change at edge N+1.
- The coin/miss to `serve_n` low interval is exactly `SERVE_DELAY_FRAMES` ticks. `serve_n` falls one cycle after the qualifying tick.
- `game_over` is high in the same cycle `attract` returns to 1.
- `reset` asserted in any state forces the reset values immediately, without waiting for `clk`. Release is synchronous to the next edge; the first transition is possible at the first edge after release.

## Configuration
- `PONG_COIN_RESTART_EN` defined: `coin` in SERVE_WAIT, SERVE or PLAY restarts the game. Scores are cleared, the counter cleared, `serve_dir`=0, and the FSM goes to SERVE_WAIT. Coin has priority over a same-cycle miss.
- Not defined: `coin` is ignored outside ATTRACT.

## Test plan
- Reset check: assert `reset` mid-simulation without a clock edge -> `attract`=1, `ball_en`=1, `serve_n`=1, scores 0 at once.
- Serve delay: `coin`, then 60 `vblank_tick` pulses -> `serve_n` low for one cycle exactly one cycle after the 60th tick, not after the 59th; `ball_en` 0 during the wait.
- Single miss: in PLAY pulse `miss_left` -> next cycle `score_r`=1, `serve_dir`=0, `ball_en`=0, state SERVE_WAIT.
- Game end: drive `score_l` to 10, then `miss_right` -> `score_l`=11, one-cycle `game_over`, `attract`=1; a further `miss_left` is ignored.
- Simultaneous misses: `miss_left` and `miss_right` in the same cycle -> only `score_r` increments.
- Reset mid-wait and restart:
  - Async `reset` during SERVE_WAIT after 30 ticks -> ATTRACT, counter 0.
  - Then `coin` with the macro defined -> a mid-PLAY coin zeroes the scores.
  - Without the macro -> a mid-PLAY coin has no effect.

Source files
------------

// File: rtl/pong_serve_seq.sv
// Pong game-flow sequencer: attract mode, post-miss serve delay, serve strobe and scores.
// Optional PONG_COIN_RESTART_EN: a coin outside attract mode restarts the game.
module pong_serve_seq #(
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int WIN_SCORE          = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vblank_tick,
    input  logic       coin,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       attract,
    output logic       ball_en,
    output logic       serve_n,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    typedef enum logic [1:0] {ATTRACT, SERVE_WAIT, SERVE, PLAY} state_t;

    localparam logic [7:0] LAST_TICK = 8'(SERVE_DELAY_FRAMES - 1);
    localparam logic [3:0] WIN       = 4'(WIN_SCORE);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] sl_nx, sr_nx;
    logic       dir_nx, go_nx;
    logic       restart;

`ifdef PONG_COIN_RESTART_EN
    assign restart = coin;
`else
    assign restart = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sl_nx    = score_l;
        sr_nx    = score_r;
        dir_nx   = serve_dir;
        go_nx    = 1'b0;
        case (state)
            ATTRACT: begin
                if (coin) begin
                    state_nx = SERVE_WAIT;
                    cnt_nx   = '0;
                    sl_nx    = '0;
                    sr_nx    = '0;
                    dir_nx   = 1'b0;
                end
            end
            SERVE_WAIT: begin
                if (restart) begin
                    state_nx = SERVE_WAIT;
                    cnt_nx   = '0;
                    sl_nx    = '0;
                    sr_nx    = '0;
                    dir_nx   = 1'b0;
                end else if (vblank_tick) begin
                    if (cnt == LAST_TICK) begin
                        state_nx = SERVE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
            end
            SERVE: begin
                if (restart) begin
                    state_nx = SERVE_WAIT;
                    cnt_nx   = '0;
                    sl_nx    = '0;
                    sr_nx    = '0;
                    dir_nx   = 1'b0;
                end else begin
                    state_nx = PLAY;
                end
            end
            PLAY: begin
                if (restart) begin
                    state_nx = SERVE_WAIT;
                    cnt_nx   = '0;
                    sl_nx    = '0;
                    sr_nx    = '0;
                    dir_nx   = 1'b0;
                end else if (miss_left || miss_right) begin
                    // left miss wins a tie; the right miss is simply dropped
                    if (miss_left) begin
                        sr_nx  = score_r + 4'd1;
                        dir_nx = 1'b0;
                    end else begin
                        sl_nx  = score_l + 4'd1;
                        dir_nx = 1'b1;
                    end
                    if (sl_nx == WIN || sr_nx == WIN) begin
                        state_nx = ATTRACT;
                        go_nx    = 1'b1;
                    end else begin
                        state_nx = SERVE_WAIT;
                        cnt_nx   = '0;
                    end
                end
            end
            default: state_nx = ATTRACT;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ATTRACT;
            cnt       <= '0;
            score_l   <= '0;
            score_r   <= '0;
            serve_dir <= 1'b0;
            game_over <= 1'b0;
            attract   <= 1'b1;
            ball_en   <= 1'b1;
            serve_n   <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            score_l   <= sl_nx;
            score_r   <= sr_nx;
            serve_dir <= dir_nx;
            game_over <= go_nx;
            attract   <= (state_nx == ATTRACT);
            ball_en   <= (state_nx != SERVE_WAIT);
            serve_n   <= (state_nx != SERVE);
        end
    end

endmodule

// File: tb/tb_pong_serve_seq.sv
// Bench for pong_serve_seq: directed game scenarios, per-cycle model compare plus literal checks.
module tb_pong_serve_seq;

    localparam int D = 60;
    localparam int W = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vblank_tick = 1'b0, coin = 1'b0, miss_left = 1'b0, miss_right = 1'b0;
    logic       attract, ball_en, serve_n, serve_dir, game_over;
    logic [3:0] score_l, score_r;

    int total = 0;
    int bad = 0;

    pong_serve_seq #(.SERVE_DELAY_FRAMES(D), .WIN_SCORE(W)) dut (
        .clk(clk), .reset(reset), .vblank_tick(vblank_tick), .coin(coin),
        .miss_left(miss_left), .miss_right(miss_right), .attract(attract),
        .ball_en(ball_en), .serve_n(serve_n), .serve_dir(serve_dir),
        .score_l(score_l), .score_r(score_r), .game_over(game_over)
    );

    always #5 clk = ~clk;

`ifdef PONG_COIN_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    // Model: game phase plus frames still to wait before the serve
    typedef enum int {M_ATTRACT, M_WAIT, M_SERVE, M_PLAY} phase_t;
    phase_t m_phase = M_ATTRACT;
    int     m_left = 0;
    int     m_sl = 0, m_sr = 0;
    bit     m_dir = 0, m_go = 0;

    task automatic m_newgame();
        m_sl = 0; m_sr = 0; m_dir = 0; m_left = D; m_phase = M_WAIT;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = M_ATTRACT; m_sl = 0; m_sr = 0; m_dir = 0; m_go = 0; m_left = 0;
        end else begin
            m_go = 0;
            if (m_phase == M_ATTRACT) begin
                if (coin) m_newgame();
            end else if (RESTART && coin) begin
                m_newgame();
            end else if (m_phase == M_WAIT) begin
                if (vblank_tick) begin
                    m_left--;
                    if (m_left == 0) m_phase = M_SERVE;
                end
            end else if (m_phase == M_SERVE) begin
                m_phase = M_PLAY;
            end else if (miss_left || miss_right) begin
                if (miss_left) begin m_sr++; m_dir = 0; end
                else begin m_sl++; m_dir = 1; end
                if (m_sl == W || m_sr == W) begin m_go = 1; m_phase = M_ATTRACT; end
                else begin m_left = D; m_phase = M_WAIT; end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("attract", int'(attract), int'(m_phase == M_ATTRACT));
        chk("ball_en", int'(ball_en), int'(m_phase != M_WAIT));
        chk("serve_n", int'(serve_n), int'(m_phase != M_SERVE));
        chk("serve_dir", int'(serve_dir), int'(m_dir));
        chk("score_l", int'(score_l), m_sl);
        chk("score_r", int'(score_r), m_sr);
        chk("game_over", int'(game_over), int'(m_go));
    end

    // Inputs are held across exactly one rising edge; returns 2ns after it
    task automatic cyc(input logic c, input logic t, input logic ml, input logic mr);
        coin = c; vblank_tick = t; miss_left = ml; miss_right = mr;
        @(posedge clk); #2;
        coin = 0; vblank_tick = 0; miss_left = 0; miss_right = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_attract", int'(attract), 1);
        chk("rst_ball_en", int'(ball_en), 1);
        chk("rst_serve_n", int'(serve_n), 1);
        chk("rst_scores", int'({score_l, score_r}), 0);
        reset = 0;
        cyc(0, 0, 0, 0);

        cyc(0, 0, 1, 0);
        chk("attract_miss_ignored", int'(score_r), 0);

        // coin with a tick: tick must not count, so 59 more ticks still no serve
        cyc(1, 1, 0, 0);
        chk("wait_ball_en", int'(ball_en), 0);
        chk("wait_attract", int'(attract), 0);
        ticks(D - 1);
        chk("no_serve_at_59", int'(serve_n), 1);
        cyc(0, 1, 0, 0);
        chk("serve_at_60", int'(serve_n), 0);
        chk("serve_ball_en", int'(ball_en), 1);
        cyc(0, 0, 0, 0);
        chk("serve_one_cycle", int'(serve_n), 1);

        cyc(0, 0, 1, 0);
        chk("miss_l_score_r", int'(score_r), 1);
        chk("miss_l_dir", int'(serve_dir), 0);
        chk("miss_l_ball_en", int'(ball_en), 0);

        ticks(D);
        cyc(0, 0, 1, 1);
        chk("simul_score_r", int'(score_r), 2);
        chk("simul_score_l", int'(score_l), 0);
        cyc(0, 0, 0, 1);
        chk("wait_miss_ignored", int'(score_l), 0);

        for (int i = 0; i < W - 1; i++) begin
            ticks(D);
            cyc(0, 0, 0, 1);
        end
        chk("score_l_10", int'(score_l), 10);
        ticks(D);
        cyc(0, 0, 0, 1);
        chk("win_score_l", int'(score_l), 11);
        chk("win_game_over", int'(game_over), 1);
        chk("win_attract", int'(attract), 1);
        chk("win_dir", int'(serve_dir), 1);
        cyc(0, 0, 0, 0);
        chk("game_over_pulse", int'(game_over), 0);
        cyc(0, 0, 1, 0);
        chk("post_win_miss", int'(score_r), 2);

        // async reset mid-wait with a nonzero score
        cyc(1, 0, 0, 0);
        ticks(D);
        cyc(0, 0, 1, 0);
        ticks(30);
        reset = 1;
        #1;
        chk("async_attract", int'(attract), 1);
        chk("async_ball_en", int'(ball_en), 1);
        chk("async_serve_n", int'(serve_n), 1);
        chk("async_score_r", int'(score_r), 0);
        cyc(0, 0, 0, 0);
        reset = 0;

        cyc(1, 0, 0, 0);
        ticks(D - 1);
        chk("restart_no_serve_59", int'(serve_n), 1);
        cyc(0, 1, 0, 0);
        chk("restart_serve_60", int'(serve_n), 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        ticks(D);
        chk("pre_coin_score_r", int'(score_r), 1);
        cyc(1, 0, 0, 0);
        if (RESTART) begin
            chk("coin_play_score_r", int'(score_r), 0);
            chk("coin_play_ball_en", int'(ball_en), 0);
        end else begin
            chk("coin_play_score_r", int'(score_r), 1);
            chk("coin_play_ball_en", int'(ball_en), 1);
        end
        cyc(0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
